cpu_bus_if: RTL and testbench
=============================

// Module: cpu_bus_if
// PURPOSE
// - Bridge between the external CPU asynchronous-SRAM-style bus (clocked by CPU CKIO, 75 MHz)
//   and the FPGA's four internal BRAM regions (controller, modulation, normal/point, stm).
// - Registers the bus, decodes the region select, issues one single-cycle write strobe per CPU
//   write access and returns region read data for CPU reads.
// - Sits at the top level between the CPU pins and the BRAM controllers.
// PARAMETERS
// - ADDR_W    14  word address width inside one region (CPU_ADDR[14:1])
// - DATA_W    16  bus data width
// - N_REGION   4  number of BRAM regions, selected by CPU_ADDR[16:15]
// PORTS
// - BUS_CLK      in   1        bus clock (CPU CKIO); all logic on the rising edge
// - BUS_RST_N    in   1        asynchronous active-low reset
// - EN           in   1        chip select, active high (= ~CS1_N)
// - WE           in   1        write enable, active high (= ~WE0_N)
// - BRAM_SELECT  in   2        region select (CPU_ADDR[16:15])
// - BRAM_ADDR    in   ADDR_W   word address (CPU_ADDR[14:1])
// - DATA_IN      in   DATA_W   write data from the CPU bus
// - RD_DATA      in   N_REGION*DATA_W  read data from the regions, region k at [k*16 +: 16]
// - REGION_EN    out  N_REGION one-hot port enable for the addressed region (held during access)
// - REGION_WE    out  N_REGION one-hot single-cycle write strobe
// - ADDR_OUT     out  ADDR_W   registered word address, shared by all regions
// - DATA_OUT     out  DATA_W   registered write data, shared by all regions
// - DATA_RD      out  DATA_W   read data to the CPU pad driver
// - DATA_OE      out  1        pad output enable (read access in progress)
// BEHAVIOUR
// Reset
// - All registers and outputs are 0 while BUS_RST_N is low.
// - Reset is asynchronous. On deassertion, the block first issues a write strobe only after an
//   EN&WE low->high transition has been seen.
// Capture
// - The CPU drives the bus about 10 ns after a CKIO edge, so no synchronizer is used.
// - Stage S1 registers EN, WE, BRAM_SELECT, BRAM_ADDR and DATA_IN every cycle.
// Write
// - wr_act = en_s1 & we_s1.
// - On the first cycle where wr_act=1 and the previous wr_act=0, REGION_WE[sel_s1] is asserted
//   for exactly 1 cycle in the next cycle (latency 2 BUS_CLK edges from the pin change).
// - ADDR_OUT and DATA_OUT carry the S1 values that were sampled on that same cycle.
// - If WE stays asserted (the CPU holds it for about 10 cycles), no further strobes are issued.
//   A new strobe requires WE or EN to return low first.
// - If EN and WE rise in the same cycle, this counts as the edge.
// - If WE falls and rises again while EN stays high, this is a second write.
// Enable
// - REGION_EN = one-hot(sel_s1) while en_s1=1, otherwise 0. It is registered alongside REGION_WE.
// Read
// - DATA_OE = en_s1 & ~we_s1.
// - DATA_RD = RD_DATA slice [sel_s1] registered one cycle after REGION_EN, giving a BRAM latency
//   of 1.
// - DATA_RD holds its last value when DATA_OE=0.
// Address changes
// - An address or select change during an active write with no new WE edge does not create a
//   strobe.
// - ADDR_OUT and DATA_OUT keep following S1, but REGION_WE stays 0.
// Mid-access reset
// - Any strobe in flight is cancelled and the edge detector clears.
// - When reset releases with EN&WE already high, no write is issued for that access.
// STRUCTURE
// - Shared package cpu_bus_pkg:
//   - region select localparams: SEL_CONTROLLER=0, SEL_MOD=1, SEL_NORMAL=2, SEL_STM=3
//   - ADDR_W / DATA_W constants
// - One sub-module, cpu_bus_edge_det: registered rising-edge detector on wr_act, reset-aware.
// TESTING
// - Reset: hold BUS_RST_N=0 with EN=WE=1 -> all outputs 0; release -> no REGION_WE pulse.
// - Single write: sel=1, addr=0x0123, data=0xBEEF, WE low for 10 cycles -> exactly one
//   REGION_WE=4'b0010 pulse with ADDR_OUT=0x0123, DATA_OUT=0xBEEF.
// - Region sweep: writes to sel 0..3 at addr 0x3FFF, data 0x0000/0xFFFF/0xA5A5/0x5A5A -> one-hot
//   strobe per region, with the correct data on each.
// - Back-to-back: two writes separated by WE deassertion (CS held low) -> two strobes; with WE
//   held throughout -> one strobe.
// - Read: EN=1, WE=0, sel=2, RD_DATA region2=0x1234 -> DATA_OE=1; DATA_RD=0x1234 within 2 cycles;
//   REGION_WE stays 0.
// - Async reset mid-write (after edge, before strobe) -> no strobe; outputs 0 immediately.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared constants and helpers for the CPU bus bridge
package cpu_bus_pkg;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 16;
  localparam int N_REGION = 4;
  localparam int SEL_W    = 2;

  localparam logic [SEL_W-1:0] SEL_CONTROLLER = 2'd0;
  localparam logic [SEL_W-1:0] SEL_MOD        = 2'd1;
  localparam logic [SEL_W-1:0] SEL_NORMAL     = 2'd2;
  localparam logic [SEL_W-1:0] SEL_STM        = 2'd3;

  function automatic logic [N_REGION-1:0] region_onehot(input logic [SEL_W-1:0] sel);
    logic [N_REGION-1:0] one;
    one = {{(N_REGION-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/cpu_bus_edge_det.sv
// rtl/cpu_bus_edge_det.sv - rising-edge detector on the write-active level
module cpu_bus_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic primed;
  logic armed;

  // armed only after a low level has been observed on valid (post-reset) capture data,
  // so an access already active when reset releases never produces an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed <= 1'b0;
      armed  <= 1'b0;
    end else begin
      primed <= 1'b1;
      armed  <= primed & ~level;
    end
  end

  assign rise = level & armed;

endmodule

// File: rtl/cpu_bus_if.sv
// rtl/cpu_bus_if.sv - CPU async-SRAM bus to four BRAM regions bridge
module cpu_bus_if
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W   = cpu_bus_pkg::ADDR_W,
  parameter int DATA_W   = cpu_bus_pkg::DATA_W,
  parameter int N_REGION = cpu_bus_pkg::N_REGION
) (
  input  logic                         BUS_CLK,
  input  logic                         BUS_RST_N,
  input  logic                         EN,
  input  logic                         WE,
  input  logic [SEL_W-1:0]             BRAM_SELECT,
  input  logic [ADDR_W-1:0]            BRAM_ADDR,
  input  logic [DATA_W-1:0]            DATA_IN,
  input  logic [N_REGION*DATA_W-1:0]   RD_DATA,
  output logic [N_REGION-1:0]          REGION_EN,
  output logic [N_REGION-1:0]          REGION_WE,
  output logic [ADDR_W-1:0]            ADDR_OUT,
  output logic [DATA_W-1:0]            DATA_OUT,
  output logic [DATA_W-1:0]            DATA_RD,
  output logic                         DATA_OE
);

  logic              en_s1;
  logic              we_s1;
  logic [SEL_W-1:0]  sel_s1;
  logic [ADDR_W-1:0] addr_s1;
  logic [DATA_W-1:0] data_s1;
  logic              rd_s2;
  logic [SEL_W-1:0]  sel_s2;
  logic              wr_act;
  logic              rd_act;
  logic              wr_rise;

  assign wr_act  = en_s1 & we_s1;
  assign rd_act  = en_s1 & ~we_s1;
  assign DATA_OE = rd_act;

  cpu_bus_edge_det u_edge_det (
    .clk   (BUS_CLK),
    .rst_n (BUS_RST_N),
    .level (wr_act),
    .rise  (wr_rise)
  );

  // CPU drives the pins well after CKIO, so the bus is captured directly without synchronizers
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      en_s1     <= 1'b0;
      we_s1     <= 1'b0;
      sel_s1    <= '0;
      addr_s1   <= '0;
      data_s1   <= '0;
      REGION_EN <= '0;
      REGION_WE <= '0;
      ADDR_OUT  <= '0;
      DATA_OUT  <= '0;
      rd_s2     <= 1'b0;
      sel_s2    <= '0;
      DATA_RD   <= '0;
    end else begin
      en_s1     <= EN;
      we_s1     <= WE;
      sel_s1    <= BRAM_SELECT;
      addr_s1   <= BRAM_ADDR;
      data_s1   <= DATA_IN;
      REGION_EN <= en_s1 ? region_onehot(sel_s1) : '0;
      REGION_WE <= wr_rise ? region_onehot(sel_s1) : '0;
      ADDR_OUT  <= addr_s1;
      DATA_OUT  <= data_s1;
      rd_s2     <= rd_act;
      sel_s2    <= sel_s1;
      // BRAM returns data one cycle after its enable; hold the pad value once the read ends
      if (rd_s2 && rd_act) begin
        DATA_RD <= RD_DATA[sel_s2*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_if.sv
// tb/tb_cpu_bus_if.sv - randomized self-checking bench for cpu_bus_if
module tb_cpu_bus_if;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        we;
  logic [1:0]  sel;
  logic [13:0] addr;
  logic [15:0] din;
  logic [63:0] rd_data;
  logic [3:0]  region_en;
  logic [3:0]  region_we;
  logic [13:0] addr_out;
  logic [15:0] data_out;
  logic [15:0] data_rd;
  logic        data_oe;

  cpu_bus_if dut (
    .BUS_CLK     (clk),
    .BUS_RST_N   (rst_n),
    .EN          (en),
    .WE          (we),
    .BRAM_SELECT (sel),
    .BRAM_ADDR   (addr),
    .DATA_IN     (din),
    .RD_DATA     (rd_data),
    .REGION_EN   (region_en),
    .REGION_WE   (region_we),
    .ADDR_OUT    (addr_out),
    .DATA_OUT    (data_out),
    .DATA_RD     (data_rd),
    .DATA_OE     (data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [1:0]  sel;
    logic [13:0] addr;
    logic [15:0] data;
  } pin_t;

  // model state: pin samples seen at the last three edges since reset release
  pin_t        hist[$];
  int          n_edges;
  logic [15:0] exp_rd;

  int          n_cmp;
  int          n_bad;
  int          we_total;
  logic [3:0]  last_we;
  logic [13:0] last_addr;
  logic [15:0] last_data;

  function automatic logic is_wr(input pin_t p);
    return p.en & p.we;
  endfunction

  function automatic logic is_rd(input pin_t p);
    return p.en & ~p.we;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      n_edges = 0;
      exp_rd  = 16'h0;
    end else begin
      if (n_edges >= 2 && is_rd(hist[hist.size()-2]) && is_rd(hist[hist.size()-1]))
        exp_rd = rd_data[32'(hist[hist.size()-2].sel) * 16 +: 16];
      hist.push_back({en, we, sel, addr, din});
      if (hist.size() > 3) void'(hist.pop_front());
      n_edges = n_edges + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    pin_t       p0;
    pin_t       p1;
    pin_t       p2;
    logic [3:0] e_en;
    logic [3:0] e_we;
    logic [13:0] e_addr;
    logic [15:0] e_data;
    logic       e_oe;
    p0 = '0; p1 = '0; p2 = '0;
    if (n_edges >= 1) p0 = hist[hist.size()-1];
    if (n_edges >= 2) p1 = hist[hist.size()-2];
    if (n_edges >= 3) p2 = hist[hist.size()-3];
    e_oe   = (n_edges >= 1) && is_rd(p0);
    e_en   = (n_edges >= 2 && p1.en) ? 4'(1 << p1.sel) : 4'h0;
    e_we   = (n_edges >= 3 && is_wr(p1) && !is_wr(p2)) ? 4'(1 << p1.sel) : 4'h0;
    e_addr = (n_edges >= 2) ? p1.addr : 14'h0;
    e_data = (n_edges >= 2) ? p1.data : 16'h0;
    chk("data_oe",   64'(data_oe),   64'(e_oe));
    chk("region_en", 64'(region_en), 64'(e_en));
    chk("region_we", 64'(region_we), 64'(e_we));
    chk("addr_out",  64'(addr_out),  64'(e_addr));
    chk("data_out",  64'(data_out),  64'(e_data));
    chk("data_rd",   64'(data_rd),   64'(exp_rd));
    if (region_we != 4'h0) begin
      we_total  = we_total + 1;
      last_we   = region_we;
      last_addr = addr_out;
      last_data = data_out;
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [1:0] s,
                       input logic [13:0] a, input logic [15:0] d);
    en = e; we = w; sel = s; addr = a; din = d;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_en"},   64'(region_en), 64'h0);
    chk({tag, "_we"},   64'(region_we), 64'h0);
    chk({tag, "_addr"}, 64'(addr_out),  64'h0);
    chk({tag, "_data"}, 64'(data_out),  64'h0);
    chk({tag, "_oe"},   64'(data_oe),   64'h0);
  endtask

  task automatic do_write(input logic [1:0] s, input logic [13:0] a, input logic [15:0] d,
                          input int hold);
    drive(1'b1, 1'b1, s, a, d);
    cyc(hold);
    drive(1'b0, 1'b0, s, a, d);
    cyc(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    logic [15:0] sweep_d [4];
    sweep_d = '{16'h0000, 16'hFFFF, 16'hA5A5, 16'h5A5A};
    n_cmp = 0; n_bad = 0; we_total = 0;
    last_we = '0; last_addr = '0; last_data = '0;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 2'd1, 14'h0155, 16'h1111);
    rd_data = 64'h0;

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    // reset held with an active write on the pins, then released mid-access
    cyc(4);
    chk_zero_outputs("reset");
    chk("reset_rd", 64'(data_rd), 64'h0);
    rst_n = 1'b1;
    c0 = we_total;
    cyc(10);
    chk("release_no_strobe", 64'(we_total - c0), 64'h0);
    drive(1'b0, 1'b0, 2'd0, 14'h0, 16'h0);
    cyc(3);

    c0 = we_total;
    do_write(2'd1, 14'h0123, 16'hBEEF, 10);
    chk("single_cnt",  64'(we_total - c0), 64'h1);
    chk("single_we",   64'(last_we),   64'h2);
    chk("single_addr", 64'(last_addr), 64'h0123);
    chk("single_data", 64'(last_data), 64'hBEEF);

    for (int i = 0; i < 4; i++) begin
      c0 = we_total;
      do_write(2'(i), 14'h3FFF, sweep_d[i], 4);
      chk("sweep_cnt",  64'(we_total - c0), 64'h1);
      chk("sweep_we",   64'(last_we),   64'(4'b0001 << i));
      chk("sweep_addr", 64'(last_addr), 64'h3FFF);
      chk("sweep_data", 64'(last_data), 64'(sweep_d[i]));
    end

    // WE toggles while CS stays asserted: two writes
    c0 = we_total;
    drive(1'b1, 1'b1, 2'd3, 14'h0010, 16'h1234);
    cyc(4);
    drive(1'b1, 1'b0, 2'd3, 14'h0010, 16'h1234);
    cyc(2);
    drive(1'b1, 1'b1, 2'd3, 14'h0011, 16'h5678);
    cyc(4);
    drive(1'b0, 1'b0, 2'd0, 14'h0, 16'h0);
    cyc(3);
    chk("b2b_cnt", 64'(we_total - c0), 64'h2);
    chk("b2b_last_data", 64'(last_data), 64'h5678);

    // WE held through an address/select change: one write
    c0 = we_total;
    drive(1'b1, 1'b1, 2'd0, 14'h0020, 16'hAAAA);
    cyc(5);
    drive(1'b1, 1'b1, 2'd2, 14'h0021, 16'hBBBB);
    cyc(6);
    drive(1'b0, 1'b0, 2'd0, 14'h0, 16'h0);
    cyc(3);
    chk("held_cnt", 64'(we_total - c0), 64'h1);
    chk("held_we",  64'(last_we), 64'h1);

    // read from region 2
    c0 = we_total;
    rd_data = {16'hCAFE, 16'h1234, 16'h5555, 16'h6666};
    drive(1'b1, 1'b0, 2'd2, 14'h0042, 16'h0);
    cyc(1);
    chk("read_oe", 64'(data_oe), 64'h1);
    cyc(2);
    chk("read_data", 64'(data_rd), 64'h1234);
    cyc(4);
    drive(1'b0, 1'b0, 2'd0, 14'h0, 16'h0);
    cyc(3);
    chk("read_no_we", 64'(we_total - c0), 64'h0);
    chk("read_hold",  64'(data_rd), 64'h1234);

    // async reset after the edge is captured, before the strobe
    c0 = we_total;
    drive(1'b1, 1'b1, 2'd1, 14'h0077, 16'h7777);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("midreset");
    #1 rst_n = 1'b1;
    cyc(8);
    chk("midreset_no_we", 64'(we_total - c0), 64'h0);
    drive(1'b0, 1'b0, 2'd0, 14'h0, 16'h0);
    cyc(3);

    for (int b = 0; b < 250; b++) begin
      int hold;
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom),
            14'($urandom), 16'($urandom));
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) begin
        rd_data = {$urandom, $urandom};
        if ($urandom_range(0, 4) == 0) addr = 14'($urandom);
        if (b % 60 == 30 && h == 0) begin
          #2 rst_n = 1'b0;
          #1 rst_n = 1'b1;
        end
        cyc(1);
      end
    end
    drive(1'b0, 1'b0, 2'd0, 14'h0, 16'h0);
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
